// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline types and constants for the CPU datapath.
package cpu_pipe_pkg;
  localparam int XLEN = 64;
  localparam int ZERO_REG = 31;
  typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/pipe_reg_en.sv
// pipe_reg_en: width-parametrised register with async active-low reset, sync clear and hold-enable.
module pipe_reg_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mem_wr_stage.sv
// mem_wr_stage: MEM->WR pipeline register with valid, stall/flush, X31 write suppression and forwarding hits.
// Optional MEMWR_PERF_CNT_EN adds saturating stall_cnt/bubble_cnt outputs.
module mem_wr_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int REG_W    = $bits(reg_idx_t),
  parameter int NUM_FWD  = 2,
  parameter int ZERO_REG = cpu_pipe_pkg::ZERO_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     Mem_valid,
  input  logic                     Mem_RegWE,
  input  logic [REG_W-1:0]         Mem_Rd,
  input  logic [DATA_W-1:0]        Mem_data,
  output logic                     Wr_valid,
  output logic                     Wr_RegWE,
  output logic [REG_W-1:0]         Wr_Rd,
  output logic [DATA_W-1:0]        Wr_data,
  input  logic [NUM_FWD*REG_W-1:0] fwd_src,
`ifdef MEMWR_PERF_CNT_EN
  output logic [31:0]              stall_cnt,
  output logic [31:0]              bubble_cnt,
`endif
  output logic [NUM_FWD-1:0]       fwd_hit
);
  logic w_we;
  assign w_we = Mem_valid & Mem_RegWE & (Mem_Rd != REG_W'(ZERO_REG));
  pipe_reg_en #(.W(2)) u_ctl (
    .clk(clk), .reset(reset), .clr(flush), .en(!stall),
    .d({Mem_valid, w_we}), .q({Wr_valid, Wr_RegWE})
  );
  // Payload is never cleared; a flush simply leaves it stale behind valid=0.
  pipe_reg_en #(.W(REG_W + DATA_W)) u_pay (
    .clk(clk), .reset(reset), .clr(1'b0), .en(!stall && !flush),
    .d({Mem_Rd, Mem_data}), .q({Wr_Rd, Wr_data})
  );
  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    assign fwd_hit[i] = Wr_RegWE & (Wr_Rd == fwd_src[i*REG_W +: REG_W]);
  end
`ifdef MEMWR_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_bubble_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && !flush && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if ((flush || (!stall && !Mem_valid)) && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_mem_wr_stage.sv
// tb_mem_wr_stage: directed self-checking bench for mem_wr_stage.
module tb_mem_wr_stage;
  logic        clk = 0, reset = 0, stall = 0, flush = 0;
  logic        Mem_valid = 0, Mem_RegWE = 0;
  logic [4:0]  Mem_Rd = 0;
  logic [63:0] Mem_data = 0;
  logic        Wr_valid, Wr_RegWE;
  logic [4:0]  Wr_Rd;
  logic [63:0] Wr_data;
  logic [9:0]  fwd_src = 0;
  logic [1:0]  fwd_hit;
  int total = 0, bad = 0;
`ifdef MEMWR_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  mem_wr_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .Mem_valid(Mem_valid), .Mem_RegWE(Mem_RegWE), .Mem_Rd(Mem_Rd), .Mem_data(Mem_data),
    .Wr_valid(Wr_valid), .Wr_RegWE(Wr_RegWE), .Wr_Rd(Wr_Rd), .Wr_data(Wr_data),
    .fwd_src(fwd_src),
`ifdef MEMWR_PERF_CNT_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .fwd_hit(fwd_hit)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic v, input logic we, input logic [4:0] rd, input logic [63:0] d);
    Mem_valid = v;
    Mem_RegWE = we;
    Mem_Rd = rd;
    Mem_data = d;
  endtask
  task automatic test_reset();
    step();
    total++;
    if ({Wr_valid, Wr_RegWE, Wr_Rd, Wr_data} !== 71'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b we=%b rd=%0d d=%h want all zero", Wr_valid, Wr_RegWE, Wr_Rd, Wr_data);
    end
    reset = 1;
  endtask
  task automatic test_load();
    load(1, 1, 5'd3, 64'hDEAD_BEEF);
    fwd_src = {5'd7, 5'd3};
    #1;
    total++;
    if (Wr_valid !== 1'b0) begin bad++; $display("FAIL no_comb_path got valid=%b want 0", Wr_valid); end
    step();
    total++;
    if ({Wr_valid, Wr_RegWE, Wr_Rd} !== {1'b1, 1'b1, 5'd3}) begin
      bad++; $display("FAIL load_ctl got v=%b we=%b rd=%0d want 1 1 3", Wr_valid, Wr_RegWE, Wr_Rd);
    end
    total++;
    if (Wr_data !== 64'hDEAD_BEEF) begin bad++; $display("FAIL load_data got %h want deadbeef", Wr_data); end
    total++;
    if (fwd_hit !== 2'b01) begin bad++; $display("FAIL load_fwd got %b want 01", fwd_hit); end
    fwd_src = {5'd3, 5'd7};
    #1;
    total++;
    if (fwd_hit !== 2'b10) begin bad++; $display("FAIL load_fwd_port1 got %b want 10", fwd_hit); end
  endtask
  task automatic test_zero_reg();
    load(1, 1, 5'd31, 64'h55);
    fwd_src = {5'd3, 5'd31};
    step();
    total++;
    if ({Wr_valid, Wr_RegWE, Wr_Rd} !== {1'b1, 1'b0, 5'd31}) begin
      bad++; $display("FAIL zero_reg got v=%b we=%b rd=%0d want 1 0 31", Wr_valid, Wr_RegWE, Wr_Rd);
    end
    total++;
    if (fwd_hit !== 2'b00) begin bad++; $display("FAIL zero_reg_fwd got %b want 00", fwd_hit); end
  endtask
  task automatic test_stall();
    load(1, 1, 5'd5, 64'h10);
    fwd_src = {5'd0, 5'd5};
    step();
    stall = 1;
    load(1, 1, 5'd6, 64'h20);
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({Wr_valid, Wr_RegWE, Wr_Rd, Wr_data} !== {1'b1, 1'b1, 5'd5, 64'h10} || fwd_hit !== 2'b01) begin
        bad++; $display("FAIL stall_hold[%0d] got rd=%0d d=%h hit=%b want rd=5 d=10 hit=01", k, Wr_Rd, Wr_data, fwd_hit);
      end
    end
    stall = 0;
    step();
    total++;
    if ({Wr_Rd, Wr_data} !== {5'd6, 64'h20}) begin
      bad++; $display("FAIL stall_release got rd=%0d d=%h want 6 20", Wr_Rd, Wr_data);
    end
  endtask
  task automatic test_flush_stall();
`ifdef MEMWR_PERF_CNT_EN
    logic [31:0] s0, b0;
    s0 = stall_cnt;
    b0 = bubble_cnt;
`endif
    fwd_src = {5'd0, 5'd6};
    stall = 1;
    flush = 1;
    step();
    stall = 0;
    flush = 0;
    total++;
    if ({Wr_valid, Wr_RegWE, fwd_hit} !== 4'b0000) begin
      bad++; $display("FAIL flush_stall got v=%b we=%b hit=%b want 0 0 00", Wr_valid, Wr_RegWE, fwd_hit);
    end
`ifdef MEMWR_PERF_CNT_EN
    total++;
    if (bubble_cnt !== b0 + 32'd1 || stall_cnt !== s0) begin
      bad++; $display("FAIL flush_cnt got s=%0d b=%0d want s=%0d b=%0d", stall_cnt, bubble_cnt, s0, b0 + 32'd1);
    end
`endif
  endtask
  task automatic test_back_to_back();
    load(1, 1, 5'd4, 64'h1);
    step();
    load(1, 1, 5'd4, 64'h2);
    total++;
    if ({Wr_RegWE, Wr_Rd, Wr_data} !== {1'b1, 5'd4, 64'h1}) begin
      bad++; $display("FAIL b2b_first got we=%b rd=%0d d=%h want 1 4 1", Wr_RegWE, Wr_Rd, Wr_data);
    end
    step();
    load(1, 0, 5'd8, 64'h3);
    total++;
    if ({Wr_RegWE, Wr_Rd, Wr_data} !== {1'b1, 5'd4, 64'h2}) begin
      bad++; $display("FAIL b2b_second got we=%b rd=%0d d=%h want 1 4 2", Wr_RegWE, Wr_Rd, Wr_data);
    end
    step();
    total++;
    if ({Wr_valid, Wr_RegWE, Wr_Rd} !== {1'b1, 1'b0, 5'd8}) begin
      bad++; $display("FAIL no_regwe got v=%b we=%b rd=%0d want 1 0 8", Wr_valid, Wr_RegWE, Wr_Rd);
    end
  endtask
  task automatic test_async_reset();
    load(1, 1, 5'd9, 64'hABCD);
    step();
    total++;
    if (Wr_RegWE !== 1'b1) begin bad++; $display("FAIL async_pre got we=%b want 1", Wr_RegWE); end
    #2;
    reset = 0;
    #1;
    total++;
    if ({Wr_valid, Wr_RegWE, Wr_Rd, Wr_data} !== 71'd0) begin
      bad++; $display("FAIL async_reset got v=%b we=%b rd=%0d d=%h want all zero", Wr_valid, Wr_RegWE, Wr_Rd, Wr_data);
    end
    #1;
    reset = 1;
    load(0, 1, 5'd9, 64'hABCD);
    step();
    total++;
    if ({Wr_valid, Wr_RegWE} !== 2'b00) begin
      bad++; $display("FAIL invalid_load got v=%b we=%b want 0 0", Wr_valid, Wr_RegWE);
    end
  endtask
`ifdef MEMWR_PERF_CNT_EN
  task automatic test_perf_sat();
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    stall = 1;
    for (int k = 0; k < 3; k++) step();
    stall = 0;
    total++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stall_sat got %h want ffffffff", stall_cnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_load();
    test_zero_reg();
    test_stall();
    test_flush_stall();
    test_back_to_back();
    test_async_reset();
`ifdef MEMWR_PERF_CNT_EN
    test_perf_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
